// File: rtl/wb_slave_if_pkg.sv
// wb_slave_if_pkg: bundle layout, response type and watchdog sizing shared by the Wishbone slave adapter.
package wb_slave_if_pkg;
    localparam int WBIF_SIZE = 40;
    localparam int CLK  = 0;
    localparam int RST  = 1;
    localparam int CYC  = 2;
    localparam int WR   = 3;
    localparam int STB  = 4;
    localparam int ACK  = 5;
    localparam int ERR  = 6;
    localparam int RTY  = 7;
    localparam int ADR  = 8;
    localparam int WDAT = 24;
    localparam int RDAT = 32;
    // Packed so the struct lands directly on bundle bits [RTY:ACK].
    typedef struct packed {
        logic rty;
        logic err;
        logic ack;
    } resp_t;
    function automatic int cnt_width(input int timeout);
        return timeout > 0 ? $clog2(timeout + 1) : 1;
    endfunction
endpackage

// File: rtl/wb_slave_if_if.sv
// wb_slave_if_if: packed Wishbone bundle; each side drives only its own fields.
interface wb_slave_if_if;
    import wb_slave_if_pkg::*;
    wire [WBIF_SIZE-1:0] bundle;
    modport master (inout bundle);
    modport slave (inout bundle);
endinterface

// File: rtl/wb_slave_if_watchdog.sv
// wb_watchdog: counts unanswered strobed cycles, fires at TIMEOUT and keeps a sticky flag.
module wb_watchdog
    import wb_slave_if_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic resp,
    output logic fire,
    output logic timeout
);
    localparam int W = cnt_width(TIMEOUT);
    logic [W-1:0] count;
    assign fire = strobe && (TIMEOUT != 0) && (count == W'(TIMEOUT));
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            count   <= (!strobe || resp || fire) ? '0 : count + W'(1);
            timeout <= timeout | fire;
        end
    end
endmodule

// File: rtl/wb_slave_if.sv
// wb_slave_if: unpacks master fields from the Wishbone bundle and packs a sanitised,
// watchdog-protected slave response back onto it.
module wb_slave_if
    import wb_slave_if_pkg::*;
#(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 8,
    parameter int TIMEOUT   = 255
) (
    output logic                 clk_o,
    output logic                 rst_o,
    wb_slave_if_if.slave         interface_io,
    output logic                 cyc_o,
    output logic                 wr_o,
    output logic                 stb_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic [DAT_WIDTH-1:0] dat_i,
    output logic                 timeout_o
);
    logic  wd_fire;
    resp_t resp;
    assign clk_o = interface_io.bundle[CLK];
    assign rst_o = interface_io.bundle[RST];
    assign cyc_o = interface_io.bundle[CYC];
    assign wr_o  = interface_io.bundle[WR];
    assign stb_o = interface_io.bundle[CYC] & interface_io.bundle[STB];
    assign adr_o = interface_io.bundle[ADR +: ADR_WIDTH];
    assign dat_o = interface_io.bundle[WDAT +: DAT_WIDTH];
    // Priority err > rty > ack keeps the response one-hot.
    always_comb begin
        resp.err = stb_o & (err_i | wd_fire);
        resp.rty = stb_o & rty_i & ~resp.err;
        resp.ack = stb_o & ack_i & ~resp.err & ~resp.rty;
    end
    assign interface_io.bundle[RTY:ACK]            = resp;
    assign interface_io.bundle[RDAT +: DAT_WIDTH]  = (resp.ack & ~wr_o) ? dat_i : '0;
    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk_o),
        .rst     (rst_o),
        .strobe  (stb_o),
        .resp    (ack_i | err_i | rty_i),
        .fire    (wd_fire),
        .timeout (timeout_o)
    );
endmodule

// File: tb/tb_wb_slave_if.sv
// tb_wb_slave_if: directed vector table plus watchdog/reset sequences for wb_slave_if (TIMEOUT=3).
module tb_wb_slave_if;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0;
    logic        wr = 1'b0;
    logic        stb = 1'b0;
    logic [15:0] adr = '0;
    logic [7:0]  wd = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        rty_i = 1'b0;
    logic [7:0]  dat_i = '0;
    logic        clk_o, rst_o, cyc_o, wr_o, stb_o, timeout_o;
    logic [15:0] adr_o;
    logic [7:0]  dat_o;
    int          n_vec = 0;
    int          n_bad = 0;
    wb_slave_if_if bus_if ();
    assign bus_if.bundle[4:0]  = {stb, wr, cyc, rst, clk};
    assign bus_if.bundle[31:8] = {wd, adr};
    wb_slave_if #(.ADR_WIDTH(16), .DAT_WIDTH(8), .TIMEOUT(3)) dut (
        .clk_o        (clk_o),
        .rst_o        (rst_o),
        .interface_io (bus_if),
        .cyc_o        (cyc_o),
        .wr_o         (wr_o),
        .stb_o        (stb_o),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .rty_i        (rty_i),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .timeout_o    (timeout_o)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        cyc, stb, wr;
        logic [15:0] adr;
        logic [7:0]  wd;
        logic        ack, err, rty;
        logic [7:0]  rd;
        logic        e_stb;
        logic [2:0]  e_resp;
        logic [7:0]  e_rd;
    } vec_t;
    vec_t vecs[9];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic idle();
        cyc = 0; stb = 0; wr = 0; ack_i = 0; err_i = 0; rty_i = 0; dat_i = '0;
    endtask
    initial begin
        // e_resp is {rty, err, ack}
        vecs[0] = '{1, 1, 1, 16'h0002, 8'hA5, 1, 0, 0, 8'h00, 1, 3'b001, 8'h00};
        vecs[1] = '{1, 1, 0, 16'h0010, 8'h00, 1, 0, 0, 8'h3C, 1, 3'b001, 8'h3C};
        vecs[2] = '{1, 1, 0, 16'h0010, 8'h00, 0, 0, 0, 8'h3C, 1, 3'b000, 8'h00};
        vecs[3] = '{1, 1, 0, 16'h1234, 8'h00, 1, 1, 1, 8'h77, 1, 3'b010, 8'h00};
        vecs[4] = '{1, 1, 0, 16'h1234, 8'h00, 1, 0, 1, 8'h77, 1, 3'b100, 8'h00};
        vecs[5] = '{0, 1, 0, 16'hFFFF, 8'h00, 1, 0, 0, 8'h3C, 0, 3'b000, 8'h00};
        vecs[6] = '{1, 0, 1, 16'h8000, 8'h5A, 0, 1, 0, 8'h00, 0, 3'b000, 8'h00};
        vecs[7] = '{1, 1, 1, 16'hBEEF, 8'hC3, 0, 1, 0, 8'h11, 1, 3'b010, 8'h00};
        vecs[8] = '{1, 1, 0, 16'h0001, 8'h00, 0, 0, 1, 8'h99, 1, 3'b100, 8'h00};
        idle();
        rst = 1;
        repeat (2) @(negedge clk);
        #1 check("reset_rst_o", 64'(rst_o), 64'd1);
        check("reset_timeout", 64'(timeout_o), 64'd0);
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            cyc = vecs[i].cyc; stb = vecs[i].stb; wr = vecs[i].wr; adr = vecs[i].adr; wd = vecs[i].wd;
            ack_i = vecs[i].ack; err_i = vecs[i].err; rty_i = vecs[i].rty; dat_i = vecs[i].rd;
            #1;
            check($sformatf("vec%0d", i),
                  64'({cyc_o, wr_o, stb_o, adr_o, dat_o, bus_if.bundle[7:5], bus_if.bundle[39:32]}),
                  64'({vecs[i].cyc, vecs[i].wr, vecs[i].e_stb, vecs[i].adr, vecs[i].wd, vecs[i].e_resp, vecs[i].e_rd}));
            @(negedge clk);
            idle();
            @(negedge clk);
        end
        // Watchdog: strobe held with no response, err on 4th cycle only.
        cyc = 1; stb = 1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check($sformatf("wd_err_c%0d", k), 64'(bus_if.bundle[7:5]), (k == 4) ? 64'b010 : 64'b000);
            check($sformatf("wd_sticky_c%0d", k), 64'(timeout_o), 64'(k >= 5));
            @(negedge clk);
        end
        idle();
        rst = 1;
        @(negedge clk);
        #1 check("rst_clears_timeout", 64'(timeout_o), 64'd0);
        rst = 0;
        @(negedge clk);
        // Counter restart: ack on 2nd cycle pushes the fire out to the 6th cycle.
        cyc = 1; stb = 1;
        for (int k = 1; k <= 6; k++) begin
            ack_i = (k == 2);
            #1;
            check($sformatf("restart_resp_c%0d", k), 64'(bus_if.bundle[7:5]),
                  (k == 6) ? 64'b010 : (k == 2) ? 64'b001 : 64'b000);
            check($sformatf("restart_sticky_c%0d", k), 64'(timeout_o), 64'd0);
            @(negedge clk);
        end
        idle();
        #1 check("restart_sticky_after", 64'(timeout_o), 64'd1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
